// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding request, single-entry output register, branch redirect.
// Optional FETCH_MISALIGNED_TRAP_EN: a misaligned branch target presents a trap NOP instead of fetching.
module fetch #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_request_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        output_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        misaligned_o
);

    localparam logic [31:0] NopInstr = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StOut,
        StFlush
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] flush_addr_q, flush_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        trap_q, trap_d;

    logic [31:0] target;
    logic        target_misaligned;

`ifdef FETCH_MISALIGNED_TRAP_EN
    assign target            = branch_target_i;
    assign target_misaligned = |branch_target_i[1:0];
`else
    assign target            = branch_target_i & 32'hFFFF_FFFC;
    assign target_misaligned = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        flush_addr_d = flush_addr_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        trap_d       = trap_q;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                if (branch_i) begin
                    pc_d = target;
                    // Without a same-edge ack the old request is still in flight and must drain.
                    if (mem_ack_i) begin
                        state_d = StReq;
                    end else begin
                        state_d      = StFlush;
                        flush_addr_d = pc_q;
                    end
                end else if (mem_ack_i) begin
                    instr_d  = mem_data_i;
                    pc_out_d = pc_q;
                    state_d  = StOut;
                end
            end
            StOut: begin
                if (branch_i) begin
                    pc_d    = target;
                    trap_d  = 1'b0;
                    state_d = StReq;
                end else if (!stall_request_i && !trap_q) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = StReq;
                end
            end
            StFlush: begin
                if (branch_i) begin
                    pc_d = target;
                end else if (mem_ack_i) begin
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A misaligned target overrides the normal redirect in every non-idle state.
        if (branch_i && target_misaligned && (state_q != StIdle)) begin
            state_d  = StOut;
            trap_d   = 1'b1;
            instr_d  = NopInstr;
            pc_out_d = target;
            pc_d     = target;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            pc_q         <= BOOT_ADDRESS;
            flush_addr_q <= 32'h0;
            instr_q      <= 32'h0;
            pc_out_q     <= 32'h0;
            trap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            flush_addr_q <= flush_addr_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            trap_q       <= trap_d;
        end
    end

    assign mem_req_o      = (state_q == StReq) || (state_q == StFlush);
    assign mem_addr_o     = (state_q == StFlush) ? flush_addr_q : pc_q;
    assign output_valid_o = (state_q == StOut);
    assign instr_o        = instr_q;
    assign pc_o           = pc_out_q;
    assign misaligned_o   = trap_q;

endmodule
